// File: rtl/ui_pkg.sv
// Shared definitions for the user-interface front end: main FSM encoding,
// display page selects and a counter-width helper.
package ui_pkg;

    typedef enum logic [1:0] {
        UI_IDLE   = 2'b00,
        UI_READY  = 2'b01,
        UI_RUN    = 2'b10,
        UI_HALTED = 2'b11
    } ui_state_e;

    localparam logic [1:0] PAGE_STATUS = 2'b00;
    localparam logic [1:0] PAGE_ALU    = 2'b01;
    localparam logic [1:0] PAGE_LOAD   = 2'b10;
    localparam logic [1:0] PAGE_STATE  = 2'b11;

    // Width of a counter that has to reach n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low 7-segment decoder, bit order {g..a}.
module hex_to_seg7 (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Segment pattern lookup for 0-F.
    always_comb begin
        seg = 7'h7F;
        unique case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/user_interface_ctrl.sv
// Board front end: conditions buttons/switches into CPU control inputs and
// shows CPU status on an 8-digit multiplexed 7-segment display and LEDs.
module user_interface_ctrl
    import ui_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SCAN_CYCLES     = 100_000,
    parameter int unsigned SAMPLE_CYCLES   = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_btn_start,
    input  logic        i_btn_step,
    input  logic        i_sw_step_mode,
    input  logic [1:0]  i_sw_disp_sel,
    input  logic        i_instr_transmit_done,
    input  logic [7:0]  i_max_addr,
    input  logic        i_halt,
    input  logic [2:0]  i_alu_op,
    input  logic [4:0]  i_flags,
    input  logic [7:0]  i_current_pc,
    input  logic [7:0]  i_current_opcode,
    input  logic [15:0] i_alu_result_low,
    input  logic [15:0] i_alu_result_high,
    output logic        o_start_cpu,
    output logic        o_step_execution,
    output logic        o_next_instr_stimulus,
    output logic        o_user_sample,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_an,
    output logic [15:0] o_led
);

    localparam int unsigned N_RAW = 5;
    localparam int unsigned DB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned SC_W  = cnt_width(SCAN_CYCLES);
    localparam int unsigned SM_W  = cnt_width(SAMPLE_CYCLES);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_CYCLES - 1);
    localparam logic [SM_W-1:0] SM_LAST = SM_W'(SAMPLE_CYCLES - 1);

    // Raw input bit positions: 0 start, 1 step, 2 step mode, 4:3 page select.
    logic [N_RAW-1:0] raw;
    logic [N_RAW-1:0] sync1, sync2;
    logic [N_RAW-1:0] db;
    logic [1:0]       db_q;
    logic             press_start, press_step;

    assign raw = {i_sw_disp_sel, i_sw_step_mode, i_btn_step, i_btn_start};

    // Two-flop synchronizer for every asynchronous input bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < N_RAW; g++) begin : g_debounce
        logic [DB_W-1:0] cnt;
        logic            stable;

        // Accept a new level once it has differed from the current one for
        // DEBOUNCE_CYCLES consecutive samples; any return restarts the count.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                cnt    <= '0;
                stable <= 1'b0;
            end else if (sync2[g] == stable) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt    <= '0;
                stable <= sync2[g];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign db[g] = stable;
    end

    // Registered rising-edge detection of the two debounced buttons.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            db_q        <= '0;
            press_start <= 1'b0;
            press_step  <= 1'b0;
        end else begin
            db_q        <= db[1:0];
            press_start <= db[0] & ~db_q[0];
            press_step  <= db[1] & ~db_q[1];
        end
    end

    assign o_step_execution = db[2];

    ui_state_e state, state_nxt;
    logic      stim_nxt;
    logic      cpu_active;

    assign cpu_active = (state == UI_RUN) || (state == UI_HALTED);

    // Main FSM state register and registered control outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                 <= UI_IDLE;
            o_start_cpu           <= 1'b0;
            o_next_instr_stimulus <= 1'b0;
        end else begin
            state                 <= state_nxt;
            o_start_cpu           <= (state_nxt == UI_RUN) || (state_nxt == UI_HALTED);
            o_next_instr_stimulus <= stim_nxt;
        end
    end

    // Next state; halt wins over a coincident step, start wins over step.
    always_comb begin
        state_nxt = state;
        stim_nxt  = 1'b0;
        unique case (state)
            UI_IDLE: begin
                if (i_instr_transmit_done) state_nxt = UI_READY;
            end
            UI_READY: begin
                if (!i_instr_transmit_done) state_nxt = UI_IDLE;
                else if (press_start)       state_nxt = UI_RUN;
            end
            UI_RUN: begin
                if (i_halt)                                state_nxt = UI_HALTED;
                else if (press_step && o_step_execution)   stim_nxt  = 1'b1;
            end
            UI_HALTED: begin
                state_nxt = UI_HALTED;
            end
        endcase
    end

    logic [SM_W-1:0] smp_cnt;

    // Periodic sample strobe while the CPU is running; counter parked at 0 otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst || !cpu_active) begin
            smp_cnt       <= '0;
            o_user_sample <= 1'b0;
        end else if (smp_cnt == SM_LAST) begin
            smp_cnt       <= '0;
            o_user_sample <= 1'b1;
        end else begin
            smp_cnt       <= smp_cnt + 1'b1;
            o_user_sample <= 1'b0;
        end
    end

    logic [SC_W-1:0] scan_cnt;
    logic [2:0]      digit_idx;

    // Digit scan: advance one digit every SCAN_CYCLES, wrapping 7 to 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SC_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    logic [31:0] disp_word;
    logic [3:0]  nibble;
    logic [6:0]  seg_raw;

    // Page multiplexer for the 32-bit display word.
    always_comb begin
        disp_word = '0;
        unique case (db[4:3])
            PAGE_STATUS: disp_word = {i_current_pc, i_current_opcode, 3'b000, i_flags,
                                      5'b00000, i_alu_op};
            PAGE_ALU:    disp_word = {i_alu_result_high, i_alu_result_low};
            PAGE_LOAD:   disp_word = {24'h0, i_max_addr};
            PAGE_STATE:  disp_word = {30'h0, state};
        endcase
    end

    assign nibble = disp_word[{digit_idx, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .hex (nibble),
        .seg (seg_raw)
    );

    // Registered display drive and status LEDs; decimal point kept dark.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_seg <= '1;
            o_an  <= '1;
            o_led <= '0;
        end else begin
            o_seg <= {1'b1, seg_raw};
            o_an  <= ~(8'h01 << digit_idx);
            o_led <= {i_max_addr, 4'h0, o_step_execution, i_halt, o_start_cpu,
                      i_instr_transmit_done};
        end
    end

endmodule

// File: tb/tb_user_interface_ctrl.sv
// Self-checking bench for user_interface_ctrl with short debounce/scan/sample periods.
module tb_user_interface_ctrl;

    localparam int DEB  = 4;
    localparam int SCAN = 2;
    localparam int SAMP = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_start, btn_step, sw_step_mode;
    logic [1:0]  sw_disp_sel;
    logic        transmit_done;
    logic [7:0]  max_addr;
    logic        halt;
    logic [2:0]  alu_op;
    logic [4:0]  flags;
    logic [7:0]  current_pc, current_opcode;
    logic [15:0] alu_low, alu_high;
    logic        start_cpu, step_execution, next_instr, user_sample;
    logic [7:0]  seg, an;
    logic [15:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    // Active-low {dp,g..a} patterns for hex digits 0-F with dp off.
    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clk = ~clk;

    user_interface_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .SCAN_CYCLES     (SCAN),
        .SAMPLE_CYCLES   (SAMP)
    ) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_btn_start           (btn_start),
        .i_btn_step            (btn_step),
        .i_sw_step_mode        (sw_step_mode),
        .i_sw_disp_sel         (sw_disp_sel),
        .i_instr_transmit_done (transmit_done),
        .i_max_addr            (max_addr),
        .i_halt                (halt),
        .i_alu_op              (alu_op),
        .i_flags               (flags),
        .i_current_pc          (current_pc),
        .i_current_opcode      (current_opcode),
        .i_alu_result_low      (alu_low),
        .i_alu_result_high     (alu_high),
        .o_start_cpu           (start_cpu),
        .o_step_execution      (step_execution),
        .o_next_instr_stimulus (next_instr),
        .o_user_sample         (user_sample),
        .o_seg                 (seg),
        .o_an                  (an),
        .o_led                 (led)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Advance until digit 0 is lit, within two full scan rotations.
    task automatic wait_digit0(output bit found);
        found = 1'b0;
        for (int i = 0; i < 16 * SCAN + 4; i++) begin
            if (an == 8'hFE) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Step press with short bounce on both edges; counts stimulus pulses seen.
    task automatic bounce_step_press(output int pulses);
        logic pat [22] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                           1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        pulses = 0;
        for (int i = 0; i < 22 + 14; i++) begin
            btn_step = (i < 22) ? pat[i] : 1'b0;
            tick();
            if (next_instr === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        bit found;
        rst = 1'b1;
        ticks(3);
        n_checks++; if (an !== 8'hFF) begin n_fail++; $display("FAIL reset_an: got %h, expected ff", an); end
        n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h, expected ff", seg); end
        n_checks++; if (start_cpu !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b, expected 0", start_cpu); end
        n_checks++; if (led !== 16'h0) begin n_fail++; $display("FAIL reset_led: got %h, expected 0000", led); end
        n_checks++; if ({next_instr, user_sample, step_execution} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got %b, expected 000", {next_instr, user_sample, step_execution});
        end
        rst = 1'b0;
        tick();
        n_checks++; if (an !== 8'hFE) begin n_fail++; $display("FAIL first_scan_an: got %h, expected fe", an); end
        sw_disp_sel = 2'b11;
        ticks(DEB + 4);
        wait_digit0(found);
        n_checks++; if (!found) begin n_fail++; $display("FAIL idle_digit0_timeout: got none, expected an=fe"); end
        n_checks++; if (seg !== seg_tab[0]) begin n_fail++; $display("FAIL idle_state_seg: got %h, expected %h", seg, seg_tab[0]); end
    endtask

    task automatic test_ready_step_dropped();
        bit found;
        int pulses;
        max_addr      = 8'h3C;
        transmit_done = 1'b1;
        ticks(3);
        wait_digit0(found);
        n_checks++; if (!found || seg !== seg_tab[1]) begin n_fail++; $display("FAIL ready_state_seg: got %h, expected %h", seg, seg_tab[1]); end
        n_checks++; if (led !== {8'h3C, 8'h01}) begin n_fail++; $display("FAIL ready_led: got %h, expected 3c01", led); end
        sw_step_mode = 1'b1;
        ticks(DEB + 4);
        n_checks++; if (step_execution !== 1'b1) begin n_fail++; $display("FAIL step_mode: got %b, expected 1", step_execution); end
        bounce_step_press(pulses);
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL ready_step_dropped: got %0d pulses, expected 0", pulses); end
        n_checks++; if (start_cpu !== 1'b0) begin n_fail++; $display("FAIL ready_no_start: got %b, expected 0", start_cpu); end
    endtask

    task automatic test_start_and_sample();
        int  n;
        bit  found;
        btn_start = 1'b1;
        n = 0;
        while (n < 40 && start_cpu !== 1'b1) begin
            tick();
            n++;
        end
        n_checks++; if (n != 2 + DEB + 1 + 1) begin n_fail++; $display("FAIL start_latency: got %0d cycles, expected %0d", n, 2 + DEB + 1 + 1); end
        tick();
        n_checks++; if (led[1] !== 1'b1) begin n_fail++; $display("FAIL run_led1: got %b, expected 1", led[1]); end
        wait_digit0(found);
        n_checks++; if (!found || seg !== seg_tab[2]) begin n_fail++; $display("FAIL run_state_seg: got %h, expected %h", seg, seg_tab[2]); end
        n = 0;
        while (n < 3 * SAMP && user_sample !== 1'b1) begin
            tick();
            n++;
        end
        n_checks++; if (user_sample !== 1'b1) begin n_fail++; $display("FAIL sample_first: got none in %0d cycles, expected a pulse", n); end
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (n < 3 * SAMP && user_sample !== 1'b1);
            n_checks++; if (n != SAMP) begin n_fail++; $display("FAIL sample_period: got %0d, expected %0d", n, SAMP); end
        end
        btn_start = 1'b0;
        ticks(DEB + 4);
    endtask

    // Random bouncing on the step button in RUN; reference: a level is accepted
    // after DEB consecutive samples differing from the accepted level, and each
    // accepted rising level yields a stimulus 4 cycles after its last sample.
    task automatic test_random_step();
        logic acc = 1'b0;
        logic cur = 1'b0;
        int   run = 0;
        int   seg_left = 0;
        int   exp_q[$];
        int   n_exp = 0;
        logic expd;
        for (int t = 1; t <= 320; t++) begin
            if (t > 300) begin
                cur = 1'b0;
            end else if (seg_left == 0) begin
                cur      = ~cur;
                seg_left = $urandom_range(1, 7);
            end
            if (t <= 300) seg_left--;
            btn_step = cur;
            tick();
            if (cur != acc) begin
                run++;
                if (run == DEB) begin
                    acc = cur;
                    run = 0;
                    if (acc) begin
                        exp_q.push_back(t + 4);
                        n_exp++;
                    end
                end
            end else begin
                run = 0;
            end
            expd = 1'b0;
            if (exp_q.size() > 0 && exp_q[0] == t) begin
                expd = 1'b1;
                void'(exp_q.pop_front());
            end
            n_checks++; if (next_instr !== expd) begin n_fail++; $display("FAIL random_step t=%0d: got %b, expected %b", t, next_instr, expd); end
        end
        n_checks++; if (n_exp == 0 || exp_q.size() != 0) begin n_fail++; $display("FAIL random_step_coverage: got %0d presses, %0d pending", n_exp, exp_q.size()); end
    endtask

    task automatic test_display();
        logic [31:0] word;
        int idx, prev, held;
        bit wrapped;
        for (int p = 0; p < 3; p++) begin
            if (p == 0) begin
                alu_high = 16'h1234;
                alu_low  = 16'hABCD;
                sw_disp_sel = 2'b01;
                word = {alu_high, alu_low};
            end else if (p == 1) begin
                current_pc     = 8'($urandom);
                current_opcode = 8'($urandom);
                flags          = 5'($urandom);
                alu_op         = 3'($urandom);
                sw_disp_sel = 2'b00;
                word = {current_pc, current_opcode, 3'b000, flags, 5'b00000, alu_op};
            end else begin
                max_addr = 8'($urandom);
                sw_disp_sel = 2'b10;
                word = {24'h0, max_addr};
            end
            ticks(DEB + 4);
            prev    = -1;
            held    = 0;
            wrapped = 1'b0;
            for (int c = 0; c < 40; c++) begin
                idx = -1;
                for (int b = 0; b < 8; b++) if (an[b] == 1'b0) idx = b;
                n_checks++; if ($countones(~an) != 1) begin n_fail++; $display("FAIL an_onehot p%0d: got %h, expected one low bit", p, an); end
                if (idx >= 0) begin
                    n_checks++; if (seg !== seg_tab[word[idx*4 +: 4]]) begin
                        n_fail++; $display("FAIL digit_seg p%0d d%0d: got %h, expected %h", p, idx, seg, seg_tab[word[idx*4 +: 4]]);
                    end
                    if (p == 0 && idx == 0) begin
                        n_checks++; if (seg !== 8'hA1) begin n_fail++; $display("FAIL digit0_D: got %h, expected a1", seg); end
                    end
                    if (idx != prev) begin
                        if (prev >= 0) begin
                            n_checks++; if (idx != (prev + 1) % 8) begin n_fail++; $display("FAIL scan_order: got %0d after %0d", idx, prev); end
                            if (prev == 7 && idx == 0) wrapped = 1'b1;
                            if (held > 0) begin
                                n_checks++; if (held != SCAN) begin n_fail++; $display("FAIL scan_dwell: got %0d, expected %0d", held, SCAN); end
                            end
                        end
                        held = (prev >= 0) ? 1 : 0;
                        prev = idx;
                    end else if (held > 0) begin
                        held++;
                    end
                end
                tick();
            end
            n_checks++; if (!wrapped) begin n_fail++; $display("FAIL scan_wrap p%0d: got no 7->0, expected wrap", p); end
        end
    endtask

    task automatic test_halt_with_step();
        int pulses = 0;
        int n;
        bit found;
        sw_disp_sel = 2'b11;
        ticks(DEB + 4);
        btn_step = 1'b1;
        ticks(2 + DEB + 1);
        halt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (next_instr === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL halt_step_dropped: got %0d pulses, expected 0", pulses); end
        n_checks++; if (start_cpu !== 1'b1) begin n_fail++; $display("FAIL halted_start: got %b, expected 1", start_cpu); end
        n_checks++; if (led[2] !== 1'b1) begin n_fail++; $display("FAIL halted_led2: got %b, expected 1", led[2]); end
        wait_digit0(found);
        n_checks++; if (!found || seg !== seg_tab[3]) begin n_fail++; $display("FAIL halted_state_seg: got %h, expected %h", seg, seg_tab[3]); end
        n = 0;
        while (n < 3 * SAMP && user_sample !== 1'b1) begin
            tick();
            n++;
        end
        n_checks++; if (user_sample !== 1'b1) begin n_fail++; $display("FAIL halted_sample: got none in %0d cycles, expected a pulse", n); end
        btn_step = 1'b0;
        halt     = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int pulses = 0;
        int starts = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ticks(DEB + 6);
        btn_start = 1'b1;
        ticks(2 + DEB + 4);
        btn_start = 1'b0;
        n_checks++; if (start_cpu !== 1'b1) begin n_fail++; $display("FAIL rerun_start: got %b, expected 1", start_cpu); end
        btn_step = 1'b1;
        ticks(3);
        rst = 1'b1;
        tick();
        n_checks++; if (start_cpu !== 1'b0) begin n_fail++; $display("FAIL midrst_start: got %b, expected 0", start_cpu); end
        n_checks++; if (an !== 8'hFF || step_execution !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs: got an=%h step=%b, expected ff 0", an, step_execution);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (next_instr === 1'b1) pulses++;
            if (start_cpu === 1'b1) starts++;
        end
        n_checks++; if (pulses != 0 || starts != 0) begin
            n_fail++; $display("FAIL midrst_quiet: got %0d stim %0d start cycles, expected 0 0", pulses, starts);
        end
        n_checks++; if (step_execution !== 1'b1) begin n_fail++; $display("FAIL midrst_step_mode: got %b, expected 1", step_execution); end
        btn_step = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        btn_start = 1'b0; btn_step = 1'b0; sw_step_mode = 1'b0; sw_disp_sel = 2'b00;
        transmit_done = 1'b0; max_addr = 8'h00; halt = 1'b0; alu_op = 3'h0; flags = 5'h0;
        current_pc = 8'h00; current_opcode = 8'h00; alu_low = 16'h0; alu_high = 16'h0;
        test_reset();
        test_ready_step_dropped();
        test_start_and_sample();
        test_random_step();
        test_display();
        test_halt_with_step();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1);
    end

endmodule
